// File: rtl/dac_out_if.sv
// dac_out_if: FIFO-buffered DAC output stage replaying samples at a programmable period.
// Build option: define DAC_OFFSET_BIN_EN to emit offset-binary codes instead of two's complement.
module dac_out_if #(
  parameter int W     = 14,
  parameter int DEPTH = 8,
  parameter int DIVW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           i_data,
  input  logic                   val_in,
  input  logic [DIVW-1:0]        div,
  input  logic                   clr_flags,
  output logic [W-1:0]           o_dac,
  output logic                   o_wr,
  output logic                   underrun,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] HALF_C = (AW+1)'(DEPTH / 2);
  localparam logic [AW:0] ONE_P  = {{AW{1'b0}}, 1'b1};
`ifdef DAC_OFFSET_BIN_EN
  localparam logic [W-1:0] MID_C = {1'b1, {(W-1){1'b0}}};
`else
  localparam logic [W-1:0] MID_C = {W{1'b0}};
`endif

  typedef enum logic [0:0] {PRIME = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [W-1:0] dac_code(input logic [W-1:0] s);
`ifdef DAC_OFFSET_BIN_EN
    return {~s[W-1], s[W-2:0]};
`else
    return s;
`endif
  endfunction

  state_t          state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [W-1:0]    dac_q, dac_d;
  logic            wr_q, wr_d, und_q, und_d, ovf_q, ovf_d;

  logic [DIVW-1:0] last_s;
  logic            empty_s, full_s, tick_s, pop_s, push_s;

  // A zero period behaves like a period of one clock.
  assign last_s  = (div == {DIVW{1'b0}}) ? {DIVW{1'b0}} : div - DIVW'(1);
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign tick_s  = (state_q == RUN) && (cnt_q >= last_s);
  assign pop_s   = tick_s && !empty_s;
  assign push_s  = val_in && (!full_s || pop_s);

  // Next-state logic for FIFO, pacing FSM, output word and sticky flags.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    wr_ptr_d = push_s ? wr_ptr_q + ONE_P : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + ONE_P : rd_ptr_q;
    dac_d    = pop_s ? dac_code(mem_q[rd_ptr_q[AW-1:0]]) : dac_q;
    wr_d     = tick_s;
    und_d    = (und_q & ~clr_flags) | (tick_s & empty_s);
    ovf_d    = (ovf_q & ~clr_flags) | (val_in & full_s & ~pop_s);

    if (push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_data;
    end else begin
      mem_d = mem_q;
    end

    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + ONE_P;
      2'b01:   fill_d = fill_q - ONE_P;
      default: fill_d = fill_q;
    endcase

    case (state_q)
      PRIME: begin
        cnt_d   = {DIVW{1'b0}};
        state_d = (fill_q >= HALF_C) ? RUN : PRIME;
      end
      RUN: begin
        if (tick_s) begin
          cnt_d   = {DIVW{1'b0}};
          state_d = empty_s ? PRIME : RUN;
        end else begin
          cnt_d   = cnt_q + DIVW'(1);
          state_d = RUN;
        end
      end
      default: begin
        cnt_d   = {DIVW{1'b0}};
        state_d = PRIME;
      end
    endcase
  end

  // State registers; reset returns to an empty, priming buffer at midscale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PRIME;
      cnt_q    <= {DIVW{1'b0}};
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      fill_q   <= {(AW+1){1'b0}};
      mem_q    <= '{default: {W{1'b0}}};
      dac_q    <= MID_C;
      wr_q     <= 1'b0;
      und_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      mem_q    <= mem_d;
      dac_q    <= dac_d;
      wr_q     <= wr_d;
      und_q    <= und_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_dac    = dac_q;
  assign o_wr     = wr_q;
  assign underrun = und_q;
  assign overflow = ovf_q;
  assign fill     = fill_q;

endmodule

// File: tb/tb_dac_out_if.sv
// Self-checking bench for dac_out_if: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_dac_out_if;
  localparam int W = 14;
  localparam int DEPTH = 8;
  localparam int DIVW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    i_data;
  logic            val_in;
  logic [DIVW-1:0] div;
  logic            clr_flags;
  logic [W-1:0]    o_dac;
  logic            o_wr;
  logic            underrun;
  logic            overflow;
  logic [3:0]      fill;

  dac_out_if #(.W(W), .DEPTH(DEPTH), .DIVW(DIVW)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .val_in(val_in), .div(div),
    .clr_flags(clr_flags), .o_dac(o_dac), .o_wr(o_wr), .underrun(underrun),
    .overflow(overflow), .fill(fill)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [W-1:0] q[$];
  bit           m_run;
  int           m_cnt;
  bit           m_und, m_ovf, m_wr;
  logic [W-1:0] m_dac;

  function automatic logic [W-1:0] conv(input logic [W-1:0] s);
`ifdef DAC_OFFSET_BIN_EN
    int v;
    v = $signed(s);
    return W'(v + (1 << (W-1)));
`else
    return s;
`endif
  endfunction

  function automatic logic [W-1:0] mid_val();
`ifdef DAC_OFFSET_BIN_EN
    return W'(1 << (W-1));
`else
    return W'(0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit m_tick_now();
    int p;
    p = (div == 0) ? 1 : int'(div);
    return m_run && (m_cnt >= p - 1);
  endfunction

  task automatic model_reset();
    q.delete();
    m_run = 0; m_cnt = 0; m_und = 0; m_ovf = 0; m_wr = 0;
    m_dac = mid_val();
  endtask

  // One clock edge of the reference: pop before push, flags set-dominant.
  task automatic model_edge();
    bit tick, pop, was_full, run_before, und_set, ovf_set;
    int fill_before;
    tick        = m_tick_now();
    was_full    = (q.size() == DEPTH);
    fill_before = q.size();
    run_before  = m_run;
    pop         = tick && (q.size() > 0);
    und_set     = tick && !pop;
    ovf_set     = 0;
    m_wr        = tick;
    if (pop) m_dac = conv(q.pop_front());
    if (val_in) begin
      if (!was_full || pop) q.push_back(i_data);
      else ovf_set = 1;
    end
    m_und = (m_und && !clr_flags) || und_set;
    m_ovf = (m_ovf && !clr_flags) || ovf_set;
    if (!run_before) begin
      m_cnt = 0;
      m_run = (fill_before >= DEPTH / 2);
    end else if (tick) begin
      m_cnt = 0;
      m_run = pop;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic chk_model();
    chk("o_wr", o_wr, m_wr);
    chk("o_dac", o_dac, m_dac);
    chk("fill", fill, q.size());
    chk("underrun", underrun, m_und);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic [DIVW-1:0] dv,
                      input logic c, input bit mchk);
    val_in = v; i_data = d; div = dv; clr_flags = c;
    @(posedge clk);
    model_edge();
    #1;
    if (mchk) chk_model();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; effects must be visible at once.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_fill", fill, 0);
    chk("rst_o_wr", o_wr, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_o_dac", o_dac, mid_val());
    model_reset();
    val_in = 1'b0; clr_flags = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         c;
    logic         e_wr;
    logic         e_mid;
    logic [W-1:0] e_s;
    int           e_fill;
    logic         e_und;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int wr_cnt, got;
    bit primed, bad;
    int rate;
    logic [DIVW-1:0] rdiv;

    rst = 1'b0; val_in = 1'b0; i_data = '0; div = 8'd1; clr_flags = 1'b0;
    model_reset();
    #3;
    chk("init_fill", fill, 0);
    chk("init_o_wr", o_wr, 0);
    chk("init_o_dac", o_dac, mid_val());
    @(negedge clk);
    rst = 1'b1;

    // Table: div=1, prime with 4 edge-case samples, drain, underrun, clear.
    tbl[0]  = '{1'b1, 14'h0001, 1'b0, 1'b0, 1'b1, 14'h0000, 1, 1'b0};
    tbl[1]  = '{1'b1, 14'h1FFF, 1'b0, 1'b0, 1'b1, 14'h0000, 2, 1'b0};
    tbl[2]  = '{1'b1, 14'h2000, 1'b0, 1'b0, 1'b1, 14'h0000, 3, 1'b0};
    tbl[3]  = '{1'b1, 14'h3FFF, 1'b0, 1'b0, 1'b1, 14'h0000, 4, 1'b0};
    tbl[4]  = '{1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 14'h0000, 4, 1'b0};
    tbl[5]  = '{1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h0001, 3, 1'b0};
    tbl[6]  = '{1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h1FFF, 2, 1'b0};
    tbl[7]  = '{1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h2000, 1, 1'b0};
    tbl[8]  = '{1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h3FFF, 0, 1'b0};
    tbl[9]  = '{1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h3FFF, 0, 1'b1};
    tbl[10] = '{1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 14'h3FFF, 0, 1'b1};
    tbl[11] = '{1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 14'h3FFF, 0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].d, 8'd1, tbl[i].c, 1'b0);
      chk($sformatf("tbl%0d_o_wr", i), o_wr, tbl[i].e_wr);
      chk($sformatf("tbl%0d_o_dac", i), o_dac, tbl[i].e_mid ? mid_val() : conv(tbl[i].e_s));
      chk($sformatf("tbl%0d_fill", i), fill, tbl[i].e_fill);
      chk($sformatf("tbl%0d_underrun", i), underrun, tbl[i].e_und);
      chk($sformatf("tbl%0d_overflow", i), overflow, 0);
    end

    // Prime / steady state at div=4, one sample every 4 cycles.
    do_reset();
    primed = 0; bad = 0;
    for (int i = 1; i <= 16; i++) begin
      for (int k = 0; k < 4; k++) begin
        step((k == 0), W'(i), 8'd4, 1'b0, 1'b1);
        if (o_wr && !primed) bad = 1;
        if (fill >= 4) primed = 1;
      end
    end
    chk("steady_no_wr_before_prime", bad, 0);
    chk("steady_no_underrun", underrun, 0);
    chk("steady_no_overflow", overflow, 0);
    for (int k = 0; k < 30; k++) step(1'b0, '0, 8'd4, 1'b0, 1'b1);

    // Overflow: 12 back-to-back samples into depth 8 with a slow period.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, W'(14'h0100 + i), 8'd200, 1'b0, 1'b1);
      if (i == 8) begin
        chk("ovf_fill_full", fill, 8);
        chk("ovf_flag", overflow, 1);
      end
    end
    got = 0;
    for (int k = 0; k < 1700; k++) begin
      step(1'b0, '0, 8'd200, 1'b0, 1'b1);
      if (o_wr && got < 8) begin
        chk($sformatf("ovf_out%0d", got), o_dac, conv(W'(14'h0100 + got)));
        got++;
      end
    end
    chk("ovf_out_count", got, 8);

    // Underrun: 4 samples at div=3, then starve.
    do_reset();
    wr_cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b1, W'(14'h1000 + i), 8'd3, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) begin
      step(1'b0, '0, 8'd3, 1'b0, 1'b1);
      if (o_wr) wr_cnt++;
    end
    chk("und_wr_count", wr_cnt, 5);
    chk("und_flag", underrun, 1);
    chk("und_hold", o_dac, conv(14'h1003));

    // Full FIFO with pushes only coincident with ticks.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, W'(14'h0200 + i), 8'd6, 1'b0, 1'b1);
    for (int k = 0; k < 60; k++) begin
      div = 8'd6;
      step(m_tick_now(), W'(14'h0300 + k), 8'd6, 1'b0, 1'b1);
    end
    chk("pushpop_fill", fill, 8);
    chk("pushpop_no_ovf", overflow, 0);

    // div=0 drains one sample per cycle, then a refresh write.
    wr_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, '0, 8'd0, 1'b0, 1'b1);
      if (o_wr) wr_cnt++;
    end
    chk("div0_wr_count", wr_cnt, 9);

    // Async reset in the middle of a burst, then priming restarts from empty.
    for (int i = 0; i < 3; i++) step(1'b1, W'(14'h0400 + i), 8'd2, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, W'(14'h0500 + i), 8'd2, 1'b0, 1'b1);
    chk("post_rst_fill", fill, 3);

    // Randomized traffic against the model.
    rate = 50; rdiv = 8'd2;
    for (int k = 0; k < 2000; k++) begin
      if (k % 64 == 0) begin
        rate = $urandom_range(15, 95);
        rdiv = DIVW'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      step(($urandom_range(0, 99) < rate), W'($urandom), rdiv,
           ($urandom_range(0, 49) == 0), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
